// File: rtl/imm_ext_queue.sv
// imm_ext_queue: buffered RV32I/RV64I immediate extender with a DEPTH-entry FIFO.
//   clk            rising-edge clock
//   reset          asynchronous active-high reset (clears pointers and count)
//   flush          synchronous discard of all queued entries; wins over push/pop
//   in_valid       producer has an entry
//   in_ready       queue can accept (!full)
//   in_instr_31_7  instruction bits [31:7]
//   in_immsrc      format select: I,S,B,J,U,Z,SH,illegal
//   in_tag         sideband tag carried with the entry
//   out_valid      head entry valid
//   out_ready      consumer accepts the head entry
//   out_immext     extended immediate of the head entry (0 when !out_valid)
//   out_tag        tag of the head entry (0 when !out_valid)
//   out_illegal    head entry had an unsupported select (0 when !out_valid)
//   out_count      current occupancy, 0..DEPTH
module imm_ext_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [24:0]              in_instr_31_7,
  input  logic [2:0]               in_immsrc,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_immext,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   out_count
);
  localparam int AW = $clog2(DEPTH);
  logic [31:7]      ins;
  logic [31:0]      e32;
  logic [XLEN-1:0]  imm;
  logic             ill;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, push, pop;
  logic [XLEN-1:0]  mem_imm [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic             mem_ill [DEPTH];
  assign ins = in_instr_31_7;
  // Sign-extending formats build a 32-bit value first, then widen by sign.
  always_comb begin
    e32 = in_immsrc == 3'b000 ? {{20{ins[31]}}, ins[31:20]} :
          in_immsrc == 3'b001 ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
          in_immsrc == 3'b010 ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
          in_immsrc == 3'b011 ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} :
          in_immsrc == 3'b100 ? {ins[31:12], 12'b0} : 32'b0;
    imm = in_immsrc == 3'b101 ? XLEN'(ins[19:15]) :
          in_immsrc == 3'b110 ? (XLEN == 64 ? XLEN'(ins[25:20]) : XLEN'(ins[24:20])) :
          XLEN'($signed(e32));
    ill = &in_immsrc;
  end
  assign full      = count == (AW+1)'(DEPTH);
  assign in_ready  = !full;
  assign out_valid = count != '0;
  // A full queue still takes a new entry when the head leaves on the same edge.
  assign push = in_valid && (!full || out_ready) && !flush;
  assign pop  = out_valid && out_ready && !flush;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_imm[wr_ptr] <= imm;
      mem_tag[wr_ptr] <= in_tag;
      mem_ill[wr_ptr] <= ill;
    end
  end
  assign out_immext  = out_valid ? mem_imm[rd_ptr] : '0;
  assign out_tag     = out_valid ? mem_tag[rd_ptr] : '0;
  assign out_illegal = out_valid && mem_ill[rd_ptr];
  assign out_count   = count;
endmodule

// File: tb/tb_imm_ext_queue.sv
// tb_imm_ext_queue: directed checks of immediate extension and queue behaviour at XLEN 32 and 64.
module tb_imm_ext_queue;
  logic        clk = 0;
  logic        reset = 1;
  logic        flush = 0;
  logic        in_valid = 0;
  logic [24:0] in_instr = '0;
  logic [2:0]  in_immsrc = '0;
  logic [4:0]  in_tag = '0;
  logic        out_ready = 0;
  logic        rdy32, rdy64, ov32, ov64, il32, il64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0]  tag32, tag64;
  logic [1:0]  cnt32, cnt64;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  imm_ext_queue #(.XLEN(32), .DEPTH(2), .TAG_W(5)) u32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr_31_7(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .out_immext(imm32), .out_tag(tag32),
    .out_illegal(il32), .out_count(cnt32));

  imm_ext_queue #(.XLEN(64), .DEPTH(2), .TAG_W(5)) u64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr_31_7(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready), .out_immext(imm64), .out_tag(tag64),
    .out_illegal(il64), .out_count(cnt64));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [24:0] v_ins [10] = '{25'h1FFE001, 25'h1FC0018, 25'h1FC001D, 25'h1FFFFE0, 25'h0004000,
                              25'h1000001, 25'h0001F00, 25'h0040000, 25'h003E000, 25'h1FFFFFF};
  logic [2:0]  v_sel [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd7};
  logic [31:0] v_e32 [10] = '{32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'hFFFFFFFE, 32'h2,
                              32'h80000000, 32'h1F, 32'h0, 32'h1F, 32'h0};
  logic [63:0] v_e64 [10] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC,
                              64'hFFFFFFFFFFFFFFFE, 64'h2, 64'hFFFFFFFF80000000, 64'h1F, 64'h20,
                              64'h1F, 64'h0};

  initial begin
    #12;
    chk("rst_valid", 64'(ov32), 64'd0);
    chk("rst_ready", 64'(rdy32), 64'd1);
    chk("rst_count", 64'(cnt64), 64'd0);
    chk("rst_imm", imm64, 64'd0);
    chk("rst_tag", 64'(tag32), 64'd0);
    chk("rst_ill", 64'(il64), 64'd0);
    #1 reset = 0;
    step();
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_instr = v_ins[i];
      in_immsrc = v_sel[i];
      in_tag = 5'(i + 1);
      in_valid = 1;
      step();
      in_valid = 0;
      chk($sformatf("ext_valid%0d", i), 64'(ov32), 64'd1);
      chk($sformatf("ext32_%0d", i), 64'(imm32), 64'(v_e32[i]));
      chk($sformatf("ext64_%0d", i), imm64, v_e64[i]);
      chk($sformatf("ill32_%0d", i), 64'(il32), 64'(i == 9));
      chk($sformatf("ill64_%0d", i), 64'(il64), 64'(i == 9));
      chk($sformatf("tag_%0d", i), 64'(tag64), 64'(i + 1));
      step();
      chk($sformatf("drain_%0d", i), 64'(cnt32), 64'd0);
    end
    out_ready = 0;
    in_immsrc = 3'd0;
    in_instr = 25'h0;
    in_valid = 1;
    in_tag = 5'd1;
    step();
    chk("fill1_ready", 64'(rdy32), 64'd1);
    chk("fill1_count", 64'(cnt32), 64'd1);
    in_tag = 5'd2;
    step();
    chk("fill2_ready", 64'(rdy32), 64'd0);
    chk("fill2_count", 64'(cnt32), 64'd2);
    in_tag = 5'd3;
    step();
    in_valid = 0;
    chk("full_count", 64'(cnt32), 64'd2);
    chk("full_head", 64'(tag32), 64'd1);
    out_ready = 1;
    chk("pop_a", 64'(tag32), 64'd1);
    step();
    chk("pop_b", 64'(tag32), 64'd2);
    chk("pop_b_ready", 64'(rdy32), 64'd1);
    step();
    chk("pop_empty", 64'(ov32), 64'd0);
    chk("pop_empty_tag", 64'(tag32), 64'd0);
    out_ready = 0;
    in_valid = 1;
    in_tag = 5'd4;
    step();
    in_tag = 5'd5;
    step();
    chk("pp_full", 64'(cnt64), 64'd2);
    in_tag = 5'd7;
    out_ready = 1;
    chk("pp_head", 64'(tag64), 64'd4);
    step();
    in_valid = 0;
    chk("pp_count", 64'(cnt64), 64'd2);
    chk("pp_next", 64'(tag64), 64'd5);
    step();
    chk("pp_last", 64'(tag64), 64'd7);
    chk("pp_last_count", 64'(cnt64), 64'd1);
    step();
    chk("pp_empty", 64'(cnt64), 64'd0);
    out_ready = 0;
    in_valid = 1;
    in_tag = 5'd8;
    step();
    step();
    chk("fl_pre", 64'(cnt32), 64'd2);
    in_tag = 5'd9;
    flush = 1;
    step();
    flush = 0;
    in_valid = 0;
    chk("fl_valid", 64'(ov32), 64'd0);
    chk("fl_count", 64'(cnt32), 64'd0);
    chk("fl_ready", 64'(rdy32), 64'd1);
    chk("fl_tag", 64'(tag32), 64'd0);
    step();
    chk("fl_dropped", 64'(ov32), 64'd0);
    in_valid = 1;
    in_tag = 5'd10;
    in_immsrc = 3'd7;
    step();
    in_valid = 0;
    chk("ar_pre_valid", 64'(ov64), 64'd1);
    chk("ar_pre_ill", 64'(il64), 64'd1);
    #2 reset = 1;
    #1;
    chk("ar_valid", 64'(ov64), 64'd0);
    chk("ar_count", 64'(cnt64), 64'd0);
    chk("ar_ready", 64'(rdy64), 64'd1);
    chk("ar_ill", 64'(il64), 64'd0);
    chk("ar_tag", 64'(tag64), 64'd0);
    #3 reset = 0;
    in_valid = 1;
    in_tag = 5'd11;
    in_immsrc = 3'd4;
    in_instr = 25'h1000001;
    step();
    in_valid = 0;
    chk("post_rst_valid", 64'(ov32), 64'd1);
    chk("post_rst_tag", 64'(tag32), 64'd11);
    chk("post_rst_imm64", imm64, 64'hFFFFFFFF80000000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imm_ext_queue.md
# imm_ext_queue

Parametrised, buffered successor to the combinational immediate extender, sitting between fetch/decode and execute. It accepts instruction bits [31:7] plus an immediate-source select over a valid/ready handshake and extends them to XLEN, either 32 or 64. It covers all RV32I/RV64I immediate formats plus CSR zimm and shift amounts, flags unsupported selects, and queues results in a DEPTH-entry FIFO with flush support.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- DEPTH, 2: FIFO entries; power of two, ≥2.
- TAG_W, 5: width of the sideband tag carried with each entry.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all queued entries.
- in_valid  in  1  producer has an entry.
- in_ready  out  1  queue can accept; equals !full.
- in_instr_31_7  in  25  instruction bits [31:7]; index i = instr bit i+7.
- in_immsrc  in  3  format select.
- in_tag  in  TAG_W  sideband, e.g. rd or ROB id; passed through unchanged.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_immext  out  XLEN  extended immediate of the head entry.
- out_tag  out  TAG_W  tag of the head entry.
- out_illegal  out  1  head entry had an unsupported select.
- out_count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Extension is computed combinationally on the input side; the extended value, tag and illegal flag are stored.
- Formats, with instr bit numbers and sign bit s = instr[31]:
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25], instr[11:7]}).
  - 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 011 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 100 U: {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN (RV64 LUI/AUIPC semantics).
  - 101 Z: zext(instr[19:15]) (CSR zimm).
  - 110 SH: zext(instr[25:20]) when XLEN=64; zext(instr[24:20]) when XLEN=32.
  - 111: immext = 0, illegal = 1. All other codes give illegal = 0.
- FIFO behaviour:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle are both allowed, including when full. A full queue still shows in_ready=0; in_ready is not combinationally dependent on out_ready.
  - Pointers wrap modulo DEPTH. out_count is 0..DEPTH.
- Flush:
  - Sets count to 0 and both pointers to 0.
  - flush wins over a simultaneous push or pop; the input is dropped.
  - Stored data is not cleared.
- Reset clears pointers and count immediately, mid-operation included. Outputs during and after reset:
  - out_valid=0, in_ready=1, out_count=0.
  - out_immext=0, out_tag=0, out_illegal=0. Data outputs are masked to 0 whenever out_valid=0.

## Timing
- Latency: 1 cycle. An entry pushed at edge N is visible on out_* after edge N. There is no combinational input-to-output path.
- Throughput: 1 entry/cycle when out_ready=1.
- When out_valid=1 and out_ready=0, out_immext, out_tag and out_illegal are held stable until the pop.
- in_ready falls in the cycle after the push that fills the queue. It rises in the cycle after the first pop or flush.
- Deassertion of reset is synchronised by the instantiating block. The queue accepts input on the first edge after reset deasserts.

## Test plan
- XLEN=32 push 0x1FFE001/I (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, immext=0xFFFFFFFF, illegal=0.
- Push 0x1FC001D/B (beq -4) -> 0xFFFFFFFC. Push 0x1000001/U (lui 0x80000) -> 0x80000000 at XLEN=32 and 0xFFFFFFFF80000000 at XLEN=64.
- Push Z with instr[19:15]=11111 -> 0x1F. Push SH with instr[25:20]=100000 -> 0x20 at XLEN=64 and 0x0 at XLEN=32. Push sel 111 -> immext=0, illegal=1.
- DEPTH=2, out_ready=0, push tags 1,2,3 on consecutive cycles:
  - in_ready drops after the second push; tag 3 is not accepted; out_count=2.
  - Raise out_ready -> tags 1 then 2 appear in order.
- Full queue, simultaneous push (tag 7) and pop -> count stays 2, order is preserved, and tag 7 emerges last.
- Flush with in_valid=1 and 2 entries queued -> next cycle out_valid=0, count=0, input dropped. Assert reset asynchronously mid-stream -> outputs go to their reset values without waiting for a clk edge.
